// File: rtl/spi_target_pkg.sv
// spi_target_pkg -- shared constants for the SPI target block.
//   FILL_BYTE     : byte shifted out when no TX data is queued
//   TXFIFO_DEPTH  : TX FIFO depth (SPI_TARGET_TXFIFO_EN builds only)
//   CNT_W         : bit counter width (8 bits per byte)
//   SYNC_DEPTH    : number of synchronizer flops ahead of edge detect
//   ST_IDLE/ACTIVE: frame state encoding
package spi_target_pkg;

    localparam logic [7:0] FILL_BYTE    = 8'hFF;
    localparam int         TXFIFO_DEPTH = 4;
    localparam int         TXPTR_W      = $clog2(TXFIFO_DEPTH);
    localparam int         CNT_W        = 3;
    localparam int         SYNC_DEPTH   = 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // MSB-first receive: new bit enters at the LSB.
    function automatic logic [7:0] shift_in(input logic [7:0] r, input logic b);
        return {r[6:0], b};
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// spi_target_sync -- SYNC_DEPTH-flop synchronizer plus one history flop for
// edge detection on the synchronized value.
//   clk, rst : system clock, async active-high reset
//   d        : asynchronous input
//   q        : synchronized level
//   rise/fall: one-cycle pulses on synchronized edges
// RST_VAL sets the reset level of every flop so an idle line produces no
// spurious edge coming out of reset.
module spi_target_sync
    import spi_target_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
)
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe <= {(SYNC_DEPTH + 1){RST_VAL}};
        else     pipe <= {pipe[SYNC_DEPTH-1:0], d};
    end

    assign q    = pipe[SYNC_DEPTH-1];
    assign rise =  pipe[SYNC_DEPTH-1] & ~pipe[SYNC_DEPTH];
    assign fall = ~pipe[SYNC_DEPTH-1] &  pipe[SYNC_DEPTH];

endmodule

// File: rtl/spi_target.sv
// spi_target -- SPI mode-0 target (CPOL=0, CPHA=0), oversampled by CLK.
//   CLK, RST            : system clock (>= 4x SCK), async active-high reset
//   SCK, MOSI, nSS      : SPI bus inputs (asynchronous to CLK)
//   MISO, MISO_OE       : serial out, output enable (high while selected)
//   RXDATA/RXVALID/RXREADY : received byte, valid/ready handshake
//   TXDATA/TXVALID/TXREADY : byte to transmit, valid/ready handshake
//   RXOVF, TXUNDER, ABORT  : one-CLK status pulses
// Build option: define SPI_TARGET_TXFIFO_EN for a 4-entry TX FIFO; otherwise
// TX storage is a single holding register.
module spi_target
    import spi_target_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       nSS,
    output logic       MISO,
    output logic       MISO_OE,
    output logic [7:0] RXDATA,
    output logic       RXVALID,
    input  logic       RXREADY,
    input  logic [7:0] TXDATA,
    input  logic       TXVALID,
    output logic       TXREADY,
    output logic       RXOVF,
    output logic       TXUNDER,
    output logic       ABORT
);

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic nss_s, nss_rise, nss_fall;

    spi_target_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .clk(CLK), .rst(RST), .d(SCK), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    spi_target_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(CLK), .rst(RST), .d(MOSI), .q(mosi_s),
        .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );
    spi_target_sync #(.RST_VAL(1'b1)) u_sync_nss (
        .clk(CLK), .rst(RST), .d(nSS), .q(nss_s), .rise(nss_rise), .fall(nss_fall)
    );

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       rx_shift;
    logic [7:0]       tx_shift;
    logic             reload_pend;   // last rise completed a byte; next fall reloads

    logic       tx_avail;
    logic [7:0] tx_head;
    logic       load, pop, wr;
    logic [7:0] load_byte;
    logic       byte_done, rx_take;
    logic       in_frame;

    // Deselect wins over a coincident SCK edge so a closing frame never
    // shifts, loads or completes a byte.
    assign in_frame  = (state == ST_ACTIVE) && !nss_rise;
    assign load      = ((state == ST_IDLE) && nss_fall) ||
                       (in_frame && sck_fall && reload_pend);
    assign pop       = load && tx_avail;
    assign load_byte = tx_avail ? tx_head : FILL_BYTE;
    assign wr        = TXVALID && TXREADY;
    assign byte_done = in_frame && sck_rise && (cnt == CNT_LAST);
    assign rx_take   = RXVALID && RXREADY;

    assign MISO    = (state == ST_ACTIVE) ? tx_shift[7] : 1'b1;
    assign MISO_OE = ~nss_s;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            reload_pend <= 1'b0;
            RXDATA      <= '0;
            RXVALID     <= 1'b0;
            RXOVF       <= 1'b0;
            TXUNDER     <= 1'b0;
            ABORT       <= 1'b0;
        end else begin
            RXOVF   <= 1'b0;
            ABORT   <= 1'b0;
            TXUNDER <= load && !tx_avail;

            if (state == ST_IDLE) begin
                if (nss_fall) begin
                    state       <= ST_ACTIVE;
                    cnt         <= '0;
                    rx_shift    <= '0;
                    reload_pend <= 1'b0;
                    tx_shift    <= load_byte;
                end
            end else if (nss_rise) begin
                state       <= ST_IDLE;
                ABORT       <= (cnt != '0);
                cnt         <= '0;
                rx_shift    <= '0;
                reload_pend <= 1'b0;
            end else begin
                if (sck_rise) begin
                    rx_shift    <= shift_in(rx_shift, mosi_s);
                    cnt         <= cnt + 1'b1;
                    reload_pend <= (cnt == CNT_LAST);
                end
                if (sck_fall) begin
                    tx_shift    <= reload_pend ? load_byte : {tx_shift[6:0], 1'b0};
                    reload_pend <= 1'b0;
                end
            end

            // A completion in the same cycle the consumer takes the old
            // byte is accepted, not an overflow.
            if (byte_done && (!RXVALID || rx_take)) begin
                RXDATA  <= shift_in(rx_shift, mosi_s);
                RXVALID <= 1'b1;
            end else begin
                if (rx_take)   RXVALID <= 1'b0;
                if (byte_done) RXOVF   <= 1'b1;
            end
        end
    end

`ifdef SPI_TARGET_TXFIFO_EN
    localparam logic [TXPTR_W:0] FIFO_FULL = (TXPTR_W + 1)'(TXFIFO_DEPTH);

    logic [7:0]         fifo_mem [TXFIFO_DEPTH];
    logic [TXPTR_W-1:0] wptr, rptr;
    logic [TXPTR_W:0]   fcnt;

    assign tx_avail = (fcnt != '0);
    assign tx_head  = fifo_mem[rptr];
    assign TXREADY  = (fcnt != FIFO_FULL);

    always_ff @(posedge CLK) begin
        if (wr) fifo_mem[wptr] <= TXDATA;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
            fcnt <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: ;
            endcase
        end
    end
`else
    logic [7:0] hold;
    logic       full;

    assign tx_avail = full;
    assign tx_head  = hold;
    assign TXREADY  = ~full;

    // wr needs !full and pop needs full, so they never coincide here.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold <= '0;
            full <= 1'b0;
        end else if (wr) begin
            hold <= TXDATA;
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
`endif

endmodule
